multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl_if.sv | 27 ++
 rtl/multi_cycle_ctrl.sv | 146 ++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath/memories.
// master = controller side, slave = datapath side.
interface multi_cycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       IR_en;
    logic       PC_en;
    logic       GRF_enable;
    logic       DM_enable;
    logic [1:0] NPC_sel;
    logic       dmem_req;
    logic       illegal;
    logic [2:0] state;

    modport master (
        input  opcode, funct, zero, imem_ready, dmem_ready,
        output IR_en, PC_en, GRF_enable, DM_enable, NPC_sel, dmem_req, illegal, state
    );

    modport slave (
        output opcode, funct, zero, imem_ready, dmem_ready,
        input  IR_en, PC_en, GRF_enable, DM_enable, NPC_sel, dmem_req, illegal, state
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS subset controller: FETCH/DECODE/EXEC/MEM/WB with combinational strobes.
// Optional MULTI_CYCLE_CTRL_PERF_EN adds a 32-bit retired-instruction counter (instr_count).
module multi_cycle_ctrl (
    input  logic               clk,
    input  logic               reset_n,
    multi_cycle_ctrl_if.master bus
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]        instr_count
`endif
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LB   = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21, OP_LW   = 6'h23, OP_SB   = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29, OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_JR  = 6'h08, FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND  = 6'h24, FN_OR = 6'h25;

    typedef enum logic [2:0] {
        CLS_ILLEGAL, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_JUMP, CLS_BRANCH
    } cls_e;

    cls_e       cls;
    logic       link;
    logic [1:0] jump_sel;
    logic       take_branch;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cls      = CLS_ILLEGAL;
        link     = 1'b0;
        jump_sel = 2'b00;
        case (bus.opcode)
            OP_RTYPE: begin
                case (bus.funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL: cls = CLS_ALU;
                    FN_JR:   begin cls = CLS_JUMP; jump_sel = 2'b10; end
                    FN_JALR: begin cls = CLS_JUMP; jump_sel = 2'b10; link = 1'b1; end
                    default: ;
                endcase
            end
            OP_ORI, OP_ADDI, OP_LUI: cls = CLS_ALU;
            OP_LW, OP_LH, OP_LB:     cls = CLS_LOAD;
            OP_SW, OP_SH, OP_SB:     cls = CLS_STORE;
            OP_J:    begin cls = CLS_JUMP; jump_sel = 2'b01; end
            OP_JAL:  begin cls = CLS_JUMP; jump_sel = 2'b01; link = 1'b1; end
            OP_BEQ, OP_BNE: cls = CLS_BRANCH;
            default: ;
        endcase
    end

    assign take_branch = ((bus.opcode == OP_BEQ) && bus.zero) ||
                         ((bus.opcode == OP_BNE) && !bus.zero);

    logic [2:0] state_q, state_d;
    logic       ir_en, pc_en, grf_en, dm_en, dreq, ill;
    logic [1:0] npc_sel;

    always_comb begin
        state_d = S_FETCH;
        ir_en   = 1'b0;
        pc_en   = 1'b0;
        grf_en  = 1'b0;
        dm_en   = 1'b0;
        dreq    = 1'b0;
        ill     = 1'b0;
        npc_sel = 2'b00;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    ir_en   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (cls)
                    CLS_ALU:             state_d = S_WB;
                    CLS_LOAD, CLS_STORE: state_d = S_MEM;
                    CLS_JUMP: begin
                        pc_en   = 1'b1;
                        npc_sel = jump_sel;
                        grf_en  = link;
                    end
                    CLS_BRANCH: begin
                        pc_en   = 1'b1;
                        npc_sel = take_branch ? 2'b11 : 2'b00;
                    end
                    default: begin
                        pc_en = 1'b1;
                        ill   = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                dreq = 1'b1;
                if (!bus.dmem_ready) begin
                    state_d = S_MEM;
                end else if (cls == CLS_STORE) begin
                    dm_en = 1'b1;
                    pc_en = 1'b1;
                end else if (cls == CLS_LOAD) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                grf_en = 1'b1;
                pc_en  = 1'b1;
            end
            default: ;  // unused codes fall back to FETCH silently
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Strobes are combinational, so they are gated by reset_n to be quiet while reset is held.
    assign bus.IR_en      = ir_en  & reset_n;
    assign bus.PC_en      = pc_en  & reset_n;
    assign bus.GRF_enable = grf_en & reset_n;
    assign bus.DM_enable  = dm_en  & reset_n;
    assign bus.dmem_req   = dreq   & reset_n;
    assign bus.illegal    = ill    & reset_n;
    assign bus.NPC_sel    = reset_n ? npc_sel : 2'b00;
    assign bus.state      = state_q;

`ifdef MULTI_CYCLE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   instr_count <= 32'd0;
        else if (pc_en) instr_count <= instr_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed vector table, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_multi_cycle_ctrl;
    localparam int MAX_CYC = 64;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus ();
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    logic [31:0] instr_count;
`endif

    multi_cycle_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef MULTI_CYCLE_CTRL_PERF_EN
        ,
        .instr_count (instr_count)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [2:0] st_hist [MAX_CYC];

    typedef struct {
        int         lat;
        logic [1:0] npc;
        int         ir_n, ir_cyc, gr_n, gr_cyc, dm_n, dm_cyc, ill_n, dreq_n, npc_bad;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         k, m, lat;
        logic [1:0] npc;
        int         gr, dm, ill, dreq;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One instruction: imem_ready low for k FETCH cycles, dmem_ready low for m MEM cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int k, input int m, output obs_t o);
        int  cyc;
        bit  done;
        o = '{lat: -1, npc: 2'b00, ir_n: 0, ir_cyc: -1, gr_n: 0, gr_cyc: -1,
              dm_n: 0, dm_cyc: -1, ill_n: 0, dreq_n: 0, npc_bad: 0};
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < MAX_CYC) begin
            @(negedge clk);
            bus.opcode     = op;
            bus.funct      = fn;
            bus.zero       = z;
            bus.imem_ready = (cyc == k) ? 1'b1 : ((cyc < k) ? 1'b0 : 1'($urandom_range(0, 1)));
            bus.dmem_ready = (cyc == k + 3 + m) ? 1'b1 :
                             ((cyc >= k + 3 && cyc < k + 3 + m) ? 1'b0 : 1'($urandom_range(0, 1)));
            #1;
            st_hist[cyc] = bus.state;
            if (bus.IR_en)      begin o.ir_n++; o.ir_cyc = cyc; end
            if (bus.GRF_enable) begin o.gr_n++; o.gr_cyc = cyc; end
            if (bus.DM_enable)  begin o.dm_n++; o.dm_cyc = cyc; end
            if (bus.illegal)    o.ill_n++;
            if (bus.dmem_req)   o.dreq_n++;
            if (!bus.PC_en && bus.NPC_sel != 2'b00) o.npc_bad++;
            if (bus.PC_en) begin
                o.lat = cyc + 1;
                o.npc = bus.NPC_sel;
                done  = 1'b1;
            end
            cyc++;
        end
    endtask

    task automatic check_instr(input string tag, input obs_t o, input int k, input int lat,
                               input logic [1:0] npc, input int gr, input int dm,
                               input int ill, input int dreq);
        check({tag, " latency"}, o.lat, lat);
        check({tag, " NPC_sel"}, 32'(o.npc), 32'(npc));
        check({tag, " IR_en count"}, o.ir_n, 1);
        check({tag, " IR_en cycle"}, o.ir_cyc, k);
        check({tag, " GRF_enable count"}, o.gr_n, gr);
        if (gr != 0) check({tag, " GRF_enable cycle"}, o.gr_cyc, lat - 1);
        check({tag, " DM_enable count"}, o.dm_n, dm);
        if (dm != 0) check({tag, " DM_enable cycle"}, o.dm_cyc, lat - 1);
        check({tag, " illegal count"}, o.ill_n, ill);
        check({tag, " dmem_req cycles"}, o.dreq_n, dreq);
        check({tag, " NPC_sel idle nonzero"}, o.npc_bad, 0);
    endtask

    // Reference model: instruction class from the MIPS encodings, then latency/strobe counts.
    typedef enum int {K_ILL, K_ALU, K_LOAD, K_STORE, K_J, K_JAL, K_JR, K_JALR, K_BEQ, K_BNE} kind_e;

    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h00}) return K_ALU;
            if (fn == 6'h08) return K_JR;
            if (fn == 6'h09) return K_JALR;
            return K_ILL;
        end
        if (op inside {6'h0D, 6'h08, 6'h0F}) return K_ALU;
        if (op inside {6'h23, 6'h21, 6'h20}) return K_LOAD;
        if (op inside {6'h2B, 6'h29, 6'h28}) return K_STORE;
        if (op == 6'h02) return K_J;
        if (op == 6'h03) return K_JAL;
        if (op == 6'h04) return K_BEQ;
        if (op == 6'h05) return K_BNE;
        return K_ILL;
    endfunction

    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int k, input int m, output int lat, output logic [1:0] npc,
                         output int gr, output int dm, output int ill, output int dreq);
        kind_e c = classify(op, fn);
        gr = 0; dm = 0; ill = 0; dreq = 0; npc = 2'b00;
        lat = k + 3;  // fetch wait + FETCH + DECODE + EXEC
        case (c)
            K_ALU:   begin lat = k + 4;     gr = 1; end
            K_LOAD:  begin lat = k + 5 + m; gr = 1; dreq = m + 1; end
            K_STORE: begin lat = k + 4 + m; dm = 1; dreq = m + 1; end
            K_J:     npc = 2'b01;
            K_JAL:   begin npc = 2'b01; gr = 1; end
            K_JR:    npc = 2'b10;
            K_JALR:  begin npc = 2'b10; gr = 1; end
            K_BEQ:   npc = z ? 2'b11 : 2'b00;
            K_BNE:   npc = z ? 2'b00 : 2'b11;
            default: ill = 1;
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       vt [26];
        obs_t       o;
        int         lat, gr, dm, ill, dreq, retired, dm_seen;
        logic [1:0] npc;
        bit         found;
        logic [5:0] pool_op [25];
        logic [5:0] pool_fn [25];

        vt[0]  = '{6'h00, 6'h20, 1'b0, 0, 0, 4, 2'd0, 1, 0, 0, 0};  // add
        vt[1]  = '{6'h00, 6'h22, 1'b1, 1, 0, 5, 2'd0, 1, 0, 0, 0};  // sub
        vt[2]  = '{6'h00, 6'h24, 1'b0, 0, 0, 4, 2'd0, 1, 0, 0, 0};  // and
        vt[3]  = '{6'h00, 6'h25, 1'b0, 0, 0, 4, 2'd0, 1, 0, 0, 0};  // or
        vt[4]  = '{6'h00, 6'h00, 1'b0, 2, 0, 6, 2'd0, 1, 0, 0, 0};  // sll
        vt[5]  = '{6'h0D, 6'h3F, 1'b0, 0, 0, 4, 2'd0, 1, 0, 0, 0};  // ori
        vt[6]  = '{6'h08, 6'h08, 1'b0, 0, 0, 4, 2'd0, 1, 0, 0, 0};  // addi
        vt[7]  = '{6'h0F, 6'h00, 1'b0, 0, 0, 4, 2'd0, 1, 0, 0, 0};  // lui
        vt[8]  = '{6'h23, 6'h00, 1'b0, 0, 0, 5, 2'd0, 1, 0, 0, 1};  // lw
        vt[9]  = '{6'h23, 6'h00, 1'b0, 0, 2, 7, 2'd0, 1, 0, 0, 3};  // lw, 2 wait
        vt[10] = '{6'h21, 6'h00, 1'b0, 0, 1, 6, 2'd0, 1, 0, 0, 2};  // lh
        vt[11] = '{6'h20, 6'h00, 1'b0, 0, 0, 5, 2'd0, 1, 0, 0, 1};  // lb
        vt[12] = '{6'h2B, 6'h00, 1'b0, 0, 0, 4, 2'd0, 0, 1, 0, 1};  // sw
        vt[13] = '{6'h29, 6'h00, 1'b0, 1, 1, 6, 2'd0, 0, 1, 0, 2};  // sh
        vt[14] = '{6'h28, 6'h00, 1'b0, 0, 0, 4, 2'd0, 0, 1, 0, 1};  // sb
        vt[15] = '{6'h02, 6'h00, 1'b0, 0, 0, 3, 2'd1, 0, 0, 0, 0};  // j
        vt[16] = '{6'h03, 6'h00, 1'b0, 0, 0, 3, 2'd1, 1, 0, 0, 0};  // jal
        vt[17] = '{6'h00, 6'h08, 1'b0, 0, 0, 3, 2'd2, 0, 0, 0, 0};  // jr
        vt[18] = '{6'h00, 6'h09, 1'b0, 0, 0, 3, 2'd2, 1, 0, 0, 0};  // jalr
        vt[19] = '{6'h04, 6'h00, 1'b1, 0, 0, 3, 2'd3, 0, 0, 0, 0};  // beq taken
        vt[20] = '{6'h04, 6'h00, 1'b0, 0, 0, 3, 2'd0, 0, 0, 0, 0};  // beq not taken
        vt[21] = '{6'h05, 6'h00, 1'b0, 0, 0, 3, 2'd3, 0, 0, 0, 0};  // bne taken
        vt[22] = '{6'h05, 6'h00, 1'b1, 0, 0, 3, 2'd0, 0, 0, 0, 0};  // bne not taken
        vt[23] = '{6'h3F, 6'h00, 1'b0, 0, 0, 3, 2'd0, 0, 0, 1, 0};  // opcode 0x3F
        vt[24] = '{6'h00, 6'h3F, 1'b0, 0, 0, 3, 2'd0, 0, 0, 1, 0};  // bad funct
        vt[25] = '{6'h01, 6'h00, 1'b0, 3, 0, 6, 2'd0, 0, 0, 1, 0};  // bad opcode, slow fetch

        for (int i = 0; i < 26; i++) begin
            pool_op[i % 25] = vt[i].op;
            pool_fn[i % 25] = vt[i].fn;
        end

        // Reset: outputs quiet even with imem_ready high in FETCH.
        bus.opcode = 6'h00; bus.funct = 6'h20; bus.zero = 1'b0;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        reset_n = 1'b0;
        #2;
        check("reset state", 32'(bus.state), 0);
        check("reset IR_en", 32'(bus.IR_en), 0);
        check("reset PC_en", 32'(bus.PC_en), 0);
        check("reset GRF_enable", 32'(bus.GRF_enable), 0);
        check("reset DM_enable", 32'(bus.DM_enable), 0);
        check("reset dmem_req", 32'(bus.dmem_req), 0);
        check("reset illegal", 32'(bus.illegal), 0);
        check("reset NPC_sel", 32'(bus.NPC_sel), 0);
`ifdef MULTI_CYCLE_CTRL_PERF_EN
        check("reset instr_count", instr_count, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        bus.imem_ready = 1'b0;
        reset_n = 1'b1;

        // add with zero-wait memories: states 0,1,2,4 then back to 0.
        run_instr(6'h00, 6'h20, 1'b0, 0, 0, o);
        check_instr("add seq", o, 0, 4, 2'b00, 1, 0, 0, 0);
        check("add st0", 32'(st_hist[0]), 0);
        check("add st1", 32'(st_hist[1]), 1);
        check("add st2", 32'(st_hist[2]), 2);
        check("add st3", 32'(st_hist[3]), 4);
        @(posedge clk);
        #1;
        check("add st4", 32'(bus.state), 0);

        run_instr(6'h23, 6'h00, 1'b0, 0, 0, o);
        check_instr("perf lw", o, 0, 5, 2'b00, 1, 0, 0, 1);
        run_instr(6'h02, 6'h00, 1'b0, 0, 0, o);
        check_instr("perf j", o, 0, 3, 2'b01, 0, 0, 0, 0);
`ifdef MULTI_CYCLE_CTRL_PERF_EN
        @(posedge clk);
        #1;
        check("instr_count after 3", instr_count, 3);
`endif

        foreach (vt[i]) begin
            run_instr(vt[i].op, vt[i].fn, vt[i].z, vt[i].k, vt[i].m, o);
            check_instr($sformatf("vec%0d", i), o, vt[i].k, vt[i].lat, vt[i].npc,
                        vt[i].gr, vt[i].dm, vt[i].ill, vt[i].dreq);
        end

        // Reset during MEM of a store: no DM_enable, state back to FETCH at once.
        bus.opcode = 6'h2B; bus.funct = 6'h00; bus.zero = 1'b0;
        found   = 1'b0;
        dm_seen = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            bus.imem_ready = 1'b1;
            bus.dmem_ready = 1'b0;
            #1;
            if (bus.DM_enable) dm_seen++;
            if (bus.state == 3'd3) found = 1'b1;
        end
        check("midrst reached MEM", 32'(found), 1);
        bus.dmem_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        check("midrst state", 32'(bus.state), 0);
        check("midrst DM_enable", 32'(bus.DM_enable), 0);
        check("midrst PC_en", 32'(bus.PC_en), 0);
        check("midrst dmem_req", 32'(bus.dmem_req), 0);
        check("midrst IR_en", 32'(bus.IR_en), 0);
`ifdef MULTI_CYCLE_CTRL_PERF_EN
        check("midrst instr_count", instr_count, 0);
`endif
        @(negedge clk);
        #1;
        if (bus.DM_enable) dm_seen++;
        check("midrst held state", 32'(bus.state), 0);
        check("midrst DM_enable seen", dm_seen, 0);
        bus.imem_ready = 1'b0;
        reset_n = 1'b1;
        run_instr(6'h00, 6'h25, 1'b0, 0, 0, o);
        check_instr("post-reset or", o, 0, 4, 2'b00, 1, 0, 0, 0);
        retired = 1;

        // Random instructions, ready patterns and zero flag against the model.
        for (int n = 0; n < 150; n++) begin
            int         p, k, m;
            logic [5:0] op, fn;
            logic       z;
            p  = $urandom_range(0, 24);
            op = pool_op[p];
            fn = (op == 6'h00) ? pool_fn[p] : 6'($urandom);
            if ($urandom_range(0, 15) == 0) op = 6'($urandom);
            z  = 1'($urandom);
            k  = $urandom_range(0, 3);
            m  = $urandom_range(0, 3);
            model(op, fn, z, k, m, lat, npc, gr, dm, ill, dreq);
            run_instr(op, fn, z, k, m, o);
            check_instr($sformatf("rnd%0d op%0h fn%0h", n, op, fn), o, k, lat, npc, gr, dm, ill, dreq);
            retired++;
        end
`ifdef MULTI_CYCLE_CTRL_PERF_EN
        @(posedge clk);
        #1;
        check("instr_count final", instr_count, 32'(retired));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
